fifo_stream_out: RTL

- Read-side drain stage placed directly downstream of `syn_fifo`.
- Issues read strobes into the FIFO's read port and absorbs its one-cycle read latency in a 2-entry output buffer.
- Presents the data as a valid/ready stream with burst framing (`m_last` every `BURST_LEN` beats).
- Sustains one beat per cycle when the consumer never stalls, and never over-reads the FIFO.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/skid_buf2.sv | 62 ++++++
 rtl/fifo_stream_out.sv | 76 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side drain path (syn_fifo and fifo_stream_out).
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    // Output buffer occupancy; the encoding is the word count itself.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    // Counter/pointer width for n states, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry register buffer. The head register drives the output directly,
// so the presented word cannot change while it is waiting to be accepted.
//
// state     | meaning
// BUF_EMPTY | no word held
// BUF_ONE   | head valid
// BUF_TWO   | head and tail valid
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int W = DATA_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output buf_state_t   occ
);

    logic [W-1:0] tail;

    // Occupancy state machine with head/tail data movement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ  <= BUF_EMPTY;
            head <= '0;
            tail <= '0;
        end else begin
            case (occ)
                BUF_EMPTY: begin
                    if (push) begin
                        head <= din;
                        occ  <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (push && pop) begin
                        head <= din;
                    end else if (push) begin
                        tail <= din;
                        occ  <= BUF_TWO;
                    end else if (pop) begin
                        occ <= BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (pop) begin
                        head <= tail;
                        occ  <= BUF_ONE;
                    end
                end
                default: occ <= BUF_EMPTY;
            endcase
        end
    end

    // The upstream credit logic must never deliver a word into a full buffer.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && (occ == BUF_TWO)));

endmodule

// File: rtl/fifo_stream_out.sv
// Drain stage for syn_fifo: issues read strobes against buffer credit, hides
// the FIFO's one-cycle read latency and frames the stream into bursts.
module fifo_stream_out
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BURST_LEN  = 4,
    localparam int CW        = clog2_min1(BURST_LEN)
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CW-1:0]         beat_cnt,
    output logic [15:0]           burst_cnt
);

    localparam logic [CW-1:0] LAST_IDX = CW'(BURST_LEN - 1);

    buf_state_t occ;
    logic       infl;
    logic       pop;
    logic [2:0] credit;

    assign m_valid = (occ != BUF_EMPTY);
    assign pop     = m_valid && m_ready;
    assign m_last  = m_valid && (beat_cnt == LAST_IDX);

    // Words held plus the word in flight, minus the one leaving this cycle.
    // Looking at pop here is what lets a read go out in the same cycle a
    // stalled consumer resumes, which keeps one beat per cycle.
    assign credit     = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
    assign fifo_rd_en = sys_rst_n && !fifo_empty && (credit < 3'd2);

    // Track the read issued last cycle; its data lands in the buffer this cycle.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            infl <= 1'b0;
        end else begin
            infl <= fifo_rd_en;
        end
    end

    // Burst framing; an empty FIFO simply pauses the count mid-burst.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            beat_cnt  <= '0;
            burst_cnt <= '0;
        end else if (pop) begin
            if (beat_cnt == LAST_IDX) begin
                beat_cnt  <= '0;
                burst_cnt <= burst_cnt + 16'd1;
            end else begin
                beat_cnt <= beat_cnt + CW'(1);
            end
        end
    end

    skid_buf2 #(
        .W(DATA_WIDTH)
    ) u_buf (
        .clk  (sys_clk),
        .rst_n(sys_rst_n),
        .push (infl),
        .pop  (pop),
        .din  (fifo_rd_data),
        .head (m_data),
        .occ  (occ)
    );

endmodule
